// File: rtl/digdug_hs_pkg.sv
// Shared constants for the DigDug hiscore transfer engine: state codes,
// transfer mode encoding and datapath widths.
package digdug_hs_pkg;

    localparam int ADDR_W = 11;
    localparam int CNT_W  = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_PAUSE_WAIT = 3'd1;
    localparam state_t ST_RD_ADDR    = 3'd2;
    localparam state_t ST_RD_DATA    = 3'd3;
    localparam state_t ST_RD_HOLD    = 3'd4;
    localparam state_t ST_WR_WAIT    = 3'd5;
    localparam state_t ST_RELEASE    = 3'd6;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    // RAM 1 is 2 KiB, so the window address simply wraps at 11 bits.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/digdug_hiscore_xfer.sv
// Hiscore transfer engine: pauses the main CPUs, takes over work RAM 1 and
// streams a window of it to the host (dump) or from the host into it (load).
module digdug_hiscore_xfer
    import digdug_hs_pkg::*;
#(
    parameter logic [ADDR_W-1:0] HS_BASE = 11'h000,
    parameter int                HS_LEN  = 64
) (
    input  logic              CL,
    input  logic              RESET_N,
    input  logic              DUMP_START,
    input  logic              LOAD_START,
    input  logic              ABORT,
    output logic              BUSY,
    output logic              DONE,
    output logic              CPU_PAUSE,
    input  logic              CPU_PAUSED,
    output logic              hs_access,
    output logic [ADDR_W-1:0] hs_address,
    output logic              hs_write,
    output logic [7:0]        hs_data_in,
    input  logic [7:0]        hs_data_out,
    output logic [7:0]        DUMP_DATA,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    input  logic [7:0]        LOAD_DATA,
    input  logic              LOAD_VALID,
    output logic              LOAD_READY
);

    localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(HS_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HS_LEN - 1);

    state_t           state;
    logic             mode;
    logic [CNT_W-1:0] count;
    logic             aborted;

    // hs_access is dropped on entry to RELEASE and CPU_PAUSE one cycle later,
    // so the CPUs never resume while this block still owns the RAM.
    always_ff @(posedge CL or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            mode       <= MODE_DUMP;
            count      <= '0;
            aborted    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            CPU_PAUSE  <= 1'b0;
            hs_access  <= 1'b0;
            hs_address <= '0;
            hs_write   <= 1'b0;
            hs_data_in <= 8'h00;
            DUMP_DATA  <= 8'h00;
            DUMP_VALID <= 1'b0;
            LOAD_READY <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (ABORT && state != ST_IDLE && state != ST_RELEASE) begin
                DUMP_VALID <= 1'b0;
                LOAD_READY <= 1'b0;
                hs_write   <= 1'b0;
                hs_access  <= 1'b0;
                aborted    <= 1'b1;
                state      <= ST_RELEASE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (DUMP_START || LOAD_START) begin
                            mode       <= DUMP_START ? MODE_DUMP : MODE_LOAD;
                            count      <= '0;
                            hs_address <= HS_BASE;
                            CPU_PAUSE  <= 1'b1;
                            BUSY       <= 1'b1;
                            state      <= ST_PAUSE_WAIT;
                        end
                    end
                    ST_PAUSE_WAIT: begin
                        if (CPU_PAUSED) begin
                            hs_access <= 1'b1;
                            if (mode == MODE_DUMP) begin
                                state <= ST_RD_ADDR;
                            end else begin
                                LOAD_READY <= 1'b1;
                                state      <= ST_WR_WAIT;
                            end
                        end
                    end
                    ST_RD_ADDR: begin
                        state <= ST_RD_DATA;
                    end
                    ST_RD_DATA: begin
                        DUMP_DATA  <= hs_data_out;
                        DUMP_VALID <= 1'b1;
                        state      <= ST_RD_HOLD;
                    end
                    ST_RD_HOLD: begin
                        if (DUMP_READY) begin
                            DUMP_VALID <= 1'b0;
                            count      <= count + CNT_W'(1);
                            hs_address <= addr_inc(hs_address);
                            if (count == LAST_IDX) begin
                                hs_access <= 1'b0;
                                state     <= ST_RELEASE;
                            end else begin
                                state <= ST_RD_ADDR;
                            end
                        end
                    end
                    // The address advances only after the write cycle so the
                    // strobe sees the address of the byte just accepted.
                    ST_WR_WAIT: begin
                        if (hs_write) begin
                            hs_write   <= 1'b0;
                            hs_address <= addr_inc(hs_address);
                            if (count == LEN_CNT) begin
                                hs_access <= 1'b0;
                                state     <= ST_RELEASE;
                            end else begin
                                LOAD_READY <= 1'b1;
                            end
                        end else if (LOAD_VALID && LOAD_READY) begin
                            hs_data_in <= LOAD_DATA;
                            hs_write   <= 1'b1;
                            LOAD_READY <= 1'b0;
                            count      <= count + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        CPU_PAUSE <= 1'b0;
                        BUSY      <= 1'b0;
                        DONE      <= ~aborted;
                        aborted   <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digdug_hiscore_xfer.sv
// Directed bench for digdug_hiscore_xfer: two instances (window at $100 and at
// $7FE) share one RAM 1 model; a monitor scoreboards every cycle.
module tb_digdug_hiscore_xfer;

    logic        CL = 1'b0;
    logic        RESET_N = 1'b1;
    logic        sel;
    logic        dump_start, load_start, abort_req, cpu_paused;
    logic        dump_ready, load_valid;
    logic [7:0]  load_data;
    logic [7:0]  hs_data_out;

    logic        a_busy, a_done, a_cpu_pause, a_hs_access, a_hs_write, a_dump_valid, a_load_ready;
    logic [10:0] a_hs_address;
    logic [7:0]  a_hs_data_in, a_dump_data;
    logic        b_busy, b_done, b_cpu_pause, b_hs_access, b_hs_write, b_dump_valid, b_load_ready;
    logic [10:0] b_hs_address;
    logic [7:0]  b_hs_data_in, b_dump_data;

    logic        a_dstart, a_lstart, b_dstart, b_lstart;
    assign a_dstart = dump_start & ~sel;
    assign a_lstart = load_start & ~sel;
    assign b_dstart = dump_start & sel;
    assign b_lstart = load_start & sel;

    always #5 CL = ~CL;

    digdug_hiscore_xfer #(.HS_BASE(11'h100), .HS_LEN(4)) dut_a (
        .CL(CL), .RESET_N(RESET_N), .DUMP_START(a_dstart), .LOAD_START(a_lstart),
        .ABORT(abort_req), .BUSY(a_busy), .DONE(a_done), .CPU_PAUSE(a_cpu_pause),
        .CPU_PAUSED(cpu_paused), .hs_access(a_hs_access), .hs_address(a_hs_address),
        .hs_write(a_hs_write), .hs_data_in(a_hs_data_in), .hs_data_out(hs_data_out),
        .DUMP_DATA(a_dump_data), .DUMP_VALID(a_dump_valid), .DUMP_READY(dump_ready),
        .LOAD_DATA(load_data), .LOAD_VALID(load_valid), .LOAD_READY(a_load_ready)
    );

    digdug_hiscore_xfer #(.HS_BASE(11'h7FE), .HS_LEN(4)) dut_b (
        .CL(CL), .RESET_N(RESET_N), .DUMP_START(b_dstart), .LOAD_START(b_lstart),
        .ABORT(abort_req), .BUSY(b_busy), .DONE(b_done), .CPU_PAUSE(b_cpu_pause),
        .CPU_PAUSED(cpu_paused), .hs_access(b_hs_access), .hs_address(b_hs_address),
        .hs_write(b_hs_write), .hs_data_in(b_hs_data_in), .hs_data_out(hs_data_out),
        .DUMP_DATA(b_dump_data), .DUMP_VALID(b_dump_valid), .DUMP_READY(dump_ready),
        .LOAD_DATA(load_data), .LOAD_VALID(load_valid), .LOAD_READY(b_load_ready)
    );

    logic        m_busy, m_done, m_cpu_pause, m_hs_access, m_hs_write, m_dump_valid, m_load_ready;
    logic [10:0] m_hs_address;
    logic [7:0]  m_hs_data_in, m_dump_data;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_done       = sel ? b_done       : a_done;
    assign m_cpu_pause  = sel ? b_cpu_pause  : a_cpu_pause;
    assign m_hs_access  = sel ? b_hs_access  : a_hs_access;
    assign m_hs_write   = sel ? b_hs_write   : a_hs_write;
    assign m_dump_valid = sel ? b_dump_valid : a_dump_valid;
    assign m_load_ready = sel ? b_load_ready : a_load_ready;
    assign m_hs_address = sel ? b_hs_address : a_hs_address;
    assign m_hs_data_in = sel ? b_hs_data_in : a_hs_data_in;
    assign m_dump_data  = sel ? b_dump_data  : a_dump_data;

    // RAM 1 model: registered read, write-through only while the block owns it.
    logic [7:0]  ram [0:2047];
    logic        pl_go;
    logic [10:0] pl_base;
    logic [7:0]  pl_first;

    always @(posedge CL) begin
        hs_data_out <= ram[m_hs_address];
        if (pl_go) begin
            for (int i = 0; i < 4; i++) ram[11'(pl_base + 11'(i))] = pl_first + 8'(i);
        end else if (m_hs_access && m_hs_write) begin
            ram[m_hs_address] = m_hs_data_in;
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0]  exp_dump[$];
    logic [10:0] exp_wr_addr[$];
    logic [7:0]  exp_wr_data[$];
    logic [7:0]  host_q[$];
    logic [7:0]  seen_bytes[$];
    logic [10:0] seen_addrs[$];
    int done_cnt, write_cnt, ready_high_cnt;
    int start_cyc, pause_rise, paused_cyc, access_rise, access_fall, pause_fall;
    int last_xfer_cyc, done_cyc, abort_cyc;
    logic prev_access, prev_pause, prev_valid, prev_ready, prev_paused;
    logic [7:0] prev_data;
    logic load_hs_last;
    logic toggle_ready;
    int gap, pause_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic monitorLoop();
        forever begin
            @(negedge CL);
            cyc++;
            load_hs_last = load_valid && m_load_ready;
            if (RESET_N) begin
                if (m_hs_write) checkOutput("write_needs_access", 32'(m_hs_access), 1);
                if (m_hs_access) checkOutput("access_needs_pause", 32'(m_cpu_pause), 1);
                if ((dump_start || load_start) && !m_busy) start_cyc = cyc;
                if (cpu_paused && !prev_paused) paused_cyc = cyc;
                if (m_cpu_pause && !prev_pause) pause_rise = cyc;
                if (!m_cpu_pause && prev_pause) pause_fall = cyc;
                if (m_hs_access && !prev_access) access_rise = cyc;
                if (!m_hs_access && prev_access) access_fall = cyc;
                if (abort_req) abort_cyc = cyc;
                if (m_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (m_load_ready) ready_high_cnt++;
                if (m_dump_valid && prev_valid && !prev_ready)
                    checkOutput("dump_data_held", 32'(m_dump_data), 32'(prev_data));
                if (m_dump_valid && dump_ready) begin
                    seen_bytes.push_back(m_dump_data);
                    last_xfer_cyc = cyc;
                    if (exp_dump.size() == 0) checkOutput("dump_unexpected", 1, 0);
                    else checkOutput("dump_byte", 32'(m_dump_data), 32'(exp_dump.pop_front()));
                end
                if (m_hs_write) begin
                    write_cnt++;
                    seen_addrs.push_back(m_hs_address);
                    last_xfer_cyc = cyc;
                    if (exp_wr_addr.size() == 0) checkOutput("write_unexpected", 1, 0);
                    else begin
                        checkOutput("write_addr", 32'(m_hs_address), 32'(exp_wr_addr.pop_front()));
                        checkOutput("write_data", 32'(m_hs_data_in), 32'(exp_wr_data.pop_front()));
                    end
                end
            end
            prev_access = m_hs_access;
            prev_pause  = m_cpu_pause;
            prev_valid  = m_dump_valid;
            prev_ready  = dump_ready;
            prev_data   = m_dump_data;
            prev_paused = cpu_paused;
        end
    endtask

    // Platform and host behaviour: CPUs halt 5 cycles after the request,
    // host offers load bytes with gaps, optional DUMP_READY toggling.
    task automatic applyStimulus();
        if (toggle_ready) dump_ready = ~dump_ready;
        if (m_cpu_pause) begin
            if (pause_cnt < 5) pause_cnt++;
            else cpu_paused = 1'b1;
        end else begin
            cpu_paused = 1'b0;
            pause_cnt  = 0;
        end
        if (load_hs_last) begin
            void'(host_q.pop_front());
            load_valid = 1'b0;
            gap = host_q.size() % 2 + 1;
        end else if (gap > 0) begin
            gap--;
        end else if (host_q.size() > 0) begin
            load_valid = 1'b1;
            load_data  = host_q[0];
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CL);
            #1;
            applyStimulus();
        end
    endtask

    task automatic clearStats();
        done_cnt = 0; write_cnt = 0; ready_high_cnt = 0;
        seen_bytes.delete(); seen_addrs.delete();
        start_cyc = -10; pause_rise = -20; paused_cyc = -30; access_rise = -40;
        access_fall = -50; pause_fall = -60; last_xfer_cyc = -70; done_cyc = -80; abort_cyc = -90;
    endtask

    task automatic preload(input logic [10:0] base, input logic [7:0] first);
        pl_base = base; pl_first = first; pl_go = 1'b1;
        step(1);
        pl_go = 1'b0;
    endtask

    task automatic expectDump(input logic [10:0] base);
        exp_dump.delete();
        for (int i = 0; i < 4; i++) exp_dump.push_back(ram[11'(base + 11'(i))]);
    endtask

    task automatic expectLoad(input logic [10:0] base, input logic [31:0] bytes);
        exp_wr_addr.delete(); exp_wr_data.delete(); host_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_wr_addr.push_back(11'(base + 11'(i)));
            exp_wr_data.push_back(bytes[31 - 8*i -: 8]);
            host_q.push_back(bytes[31 - 8*i -: 8]);
        end
        gap = 0;
    endtask

    task automatic startXfer(input logic d, input logic l);
        clearStats();
        step(1);
        dump_start = d; load_start = l;
        step(1);
        dump_start = 1'b0; load_start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            step(1);
            n++;
        end
        if (m_busy) checkOutput("timeout_busy", 1, 0);
        @(negedge CL);
        #1;
    endtask

    task automatic checkTransfer(input int exp_done, input bit was_aborted);
        checkOutput("done_count", 32'(done_cnt), 32'(exp_done));
        checkOutput("pause_after_start", 32'(pause_rise), 32'(start_cyc + 1));
        checkOutput("access_after_paused", 32'(access_rise), 32'(paused_cyc + 1));
        checkOutput("pause_after_access", 32'(pause_fall), 32'(access_fall + 1));
        if (!was_aborted) begin
            checkOutput("access_after_last", 32'(access_fall), 32'(last_xfer_cyc + 1));
            checkOutput("done_cycle", 32'(done_cyc), 32'(access_fall + 1));
        end
    endtask

    task automatic runDump(input bit toggle);
        preload(11'h100, 8'hA0);
        expectDump(11'h100);
        toggle_ready = toggle;
        dump_ready   = ~toggle;
        startXfer(1'b1, 1'b0);
        waitIdle(300);
        toggle_ready = 1'b0;
        dump_ready   = 1'b1;
        checkTransfer(1, 1'b0);
        checkOutput("dump_count", 32'(seen_bytes.size()), 4);
        checkOutput("dump_byte0", 32'(seen_bytes[0]), 32'h A0);
        checkOutput("dump_byte3", 32'(seen_bytes[3]), 32'h A3);
        checkOutput("dump_no_load_ready", 32'(ready_high_cnt), 0);
    endtask

    initial begin
        int n;
        sel = 1'b0; dump_start = 1'b0; load_start = 1'b0; abort_req = 1'b0;
        cpu_paused = 1'b0; dump_ready = 1'b1; load_valid = 1'b0; load_data = 8'h00;
        pl_go = 1'b0; pl_base = '0; pl_first = '0; toggle_ready = 1'b0;
        gap = 0; pause_cnt = 0; load_hs_last = 1'b0;
        prev_access = 0; prev_pause = 0; prev_valid = 0; prev_ready = 0; prev_paused = 0; prev_data = 0;
        clearStats();
        fork
            monitorLoop();
        join_none

        #2 RESET_N = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(m_busy), 0);
        checkOutput("rst_done", 32'(m_done), 0);
        checkOutput("rst_cpu_pause", 32'(m_cpu_pause), 0);
        checkOutput("rst_access", 32'(m_hs_access), 0);
        checkOutput("rst_address", 32'(m_hs_address), 0);
        checkOutput("rst_write", 32'(m_hs_write), 0);
        checkOutput("rst_data_in", 32'(m_hs_data_in), 0);
        checkOutput("rst_dump_data", 32'(m_dump_data), 0);
        checkOutput("rst_dump_valid", 32'(m_dump_valid), 0);
        checkOutput("rst_load_ready", 32'(m_load_ready), 0);
        step(2);
        RESET_N = 1'b1;
        step(2);

        $display("[TB] dump, host always ready");
        runDump(1'b0);

        $display("[TB] dump, host ready toggling");
        runDump(1'b1);

        $display("[TB] load into $100");
        expectLoad(11'h100, 32'h5AC300FF);
        startXfer(1'b0, 1'b1);
        waitIdle(300);
        checkTransfer(1, 1'b0);
        checkOutput("load_writes", 32'(write_cnt), 4);
        checkOutput("ram_100", 32'(ram[11'h100]), 32'h5A);
        checkOutput("ram_101", 32'(ram[11'h101]), 32'hC3);
        checkOutput("ram_102", 32'(ram[11'h102]), 32'h00);
        checkOutput("ram_103", 32'(ram[11'h103]), 32'hFF);

        $display("[TB] load wrapping at $7FF");
        sel = 1'b1;
        expectLoad(11'h7FE, 32'h11223344);
        startXfer(1'b0, 1'b1);
        waitIdle(300);
        checkTransfer(1, 1'b0);
        checkOutput("wrap_writes", 32'(write_cnt), 4);
        checkOutput("wrap_addr2", 32'(seen_addrs[2]), 32'h000);
        checkOutput("wrap_addr3", 32'(seen_addrs[3]), 32'h001);
        checkOutput("ram_7FF", 32'(ram[11'h7FF]), 32'h22);
        checkOutput("ram_001", 32'(ram[11'h001]), 32'h44);
        sel = 1'b0;
        step(2);

        $display("[TB] abort after two dump bytes");
        preload(11'h100, 8'hA0);
        expectDump(11'h100);
        dump_ready = 1'b1;
        startXfer(1'b1, 1'b0);
        n = 0;
        while (seen_bytes.size() < 2 && n < 200) begin step(1); n++; end
        if (seen_bytes.size() < 2) checkOutput("timeout_two_bytes", 1, 0);
        dump_ready = 1'b0;
        n = 0;
        while (!m_dump_valid && n < 20) begin step(1); n++; end
        checkOutput("stalled_valid_before_abort", 32'(m_dump_valid), 1);
        abort_req = 1'b1;
        step(1);
        abort_req = 1'b0;
        checkOutput("abort_valid_low", 32'(m_dump_valid), 0);
        checkOutput("abort_access_low", 32'(m_hs_access), 0);
        checkOutput("abort_pause_held", 32'(m_cpu_pause), 1);
        waitIdle(50);
        checkTransfer(0, 1'b1);
        checkOutput("abort_access_fall", 32'(access_fall), 32'(abort_cyc + 1));
        checkOutput("abort_bytes", 32'(seen_bytes.size()), 2);
        exp_dump.delete();
        dump_ready = 1'b1;
        step(2);
        runDump(1'b0);

        $display("[TB] simultaneous starts and start while busy");
        preload(11'h100, 8'hA0);
        expectDump(11'h100);
        host_q.delete();
        startXfer(1'b1, 1'b1);
        step(3);
        load_start = 1'b1;
        step(1);
        load_start = 1'b0;
        waitIdle(300);
        checkTransfer(1, 1'b0);
        checkOutput("both_dump_bytes", 32'(seen_bytes.size()), 4);
        checkOutput("both_no_writes", 32'(write_cnt), 0);
        checkOutput("both_no_load_ready", 32'(ready_high_cnt), 0);
        step(2);
        checkOutput("ignored_start_idle", 32'(m_busy), 0);

        $display("[TB] reset during load");
        expectLoad(11'h100, 32'h01020304);
        startXfer(1'b0, 1'b1);
        n = 0;
        while (write_cnt < 1 && n < 200) begin step(1); n++; end
        if (write_cnt < 1) checkOutput("timeout_first_write", 1, 0);
        @(negedge CL);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(m_busy), 0);
        checkOutput("arst_cpu_pause", 32'(m_cpu_pause), 0);
        checkOutput("arst_access", 32'(m_hs_access), 0);
        checkOutput("arst_write", 32'(m_hs_write), 0);
        checkOutput("arst_address", 32'(m_hs_address), 0);
        checkOutput("arst_load_ready", 32'(m_load_ready), 0);
        host_q.delete(); exp_wr_addr.delete(); exp_wr_data.delete();
        load_valid = 1'b0;
        step(2);
        RESET_N = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/digdug_hiscore_xfer.md
# digdug_hiscore_xfer

Hiscore transfer engine driving the hiscore port of the DigDug I/O device: pauses the main CPU, takes over work RAM 1 ($8800-$8FFF) through `hs_access`, and either streams a RAM window out to the host (DUMP) or streams host bytes into it (LOAD). It sits between the platform's host/save-state bridge and the I/O device, and is the initiator for the `hs_*` responder port.

## Interface
Parameters:
- HS_BASE, 11'h000, first RAM 1 byte offset of the hiscore window
- HS_LEN, 64, window length in bytes (1..2048)

Ports (one clock; reset is asynchronous and active-low):
- CL  in  1  system clock (same clock as the I/O device CPU interface)
- RESET_N  in  1  asynchronous active-low reset
- DUMP_START  in  1  one-cycle request: RAM -> host
- LOAD_START  in  1  one-cycle request: host -> RAM
- ABORT  in  1  one-cycle request: terminate the current transfer
- BUSY  out  1  high from accepted start until RELEASE completes
- DONE  out  1  one-cycle pulse on normal completion (not on abort)
- CPU_PAUSE  out  1  request to halt the main CPUs
- CPU_PAUSED  in  1  CPUs halted, bus idle
- hs_access  out  1  RAM 1 ownership to this block
- hs_address  out  11  RAM 1 byte address
- hs_write  out  1  RAM 1 write strobe
- hs_data_in  out  8  write data to RAM 1
- hs_data_out  in  8  read data from RAM 1 (one-cycle registered read)
- DUMP_DATA  out  8  byte to host
- DUMP_VALID  out  1  DUMP_DATA valid
- DUMP_READY  in  1  host accepts DUMP_DATA
- LOAD_DATA  in  8  byte from host
- LOAD_VALID  in  1  LOAD_DATA valid
- LOAD_READY  out  1  block accepts LOAD_DATA

## Operation
- States: IDLE, PAUSE_WAIT, RD_ADDR, RD_DATA, RD_HOLD, WR_WAIT, RELEASE.
- IDLE: DUMP_START -> PAUSE_WAIT (mode=dump); LOAD_START -> PAUSE_WAIT (mode=load); both same cycle: dump wins. Starts outside IDLE are ignored. On acceptance: byte counter := 0, address := HS_BASE, CPU_PAUSE := 1, BUSY := 1.
- PAUSE_WAIT: wait for CPU_PAUSED=1; then hs_access := 1, go to RD_ADDR (dump) or WR_WAIT (load).
- RD_ADDR: hs_address valid; next state RD_DATA.
- RD_DATA: capture hs_data_out into DUMP_DATA, DUMP_VALID := 1, go to RD_HOLD.
- RD_HOLD: on DUMP_VALID & DUMP_READY: DUMP_VALID := 0, count+1, address+1; if count was HS_LEN-1 -> RELEASE else RD_ADDR.
- WR_WAIT: LOAD_READY=1. On LOAD_VALID & LOAD_READY: hs_address/hs_data_in/hs_write=1 for exactly that cycle's registered write (write strobe issued the following cycle, LOAD_READY low that cycle), count+1, address+1; after HS_LEN-th byte -> RELEASE.
- RELEASE: hs_access := 0 this cycle; next cycle CPU_PAUSE := 0, BUSY := 0, DONE pulse (unless aborted), -> IDLE.
- ABORT in any state other than IDLE/RELEASE: DUMP_VALID, LOAD_READY, hs_write := 0 immediately (next edge), -> RELEASE, DONE suppressed. ABORT in IDLE ignored.
- Address arithmetic: 11-bit, wraps 11'h7FF -> 11'h000. Counter width 12 bits so HS_LEN=2048 is legal.
- Invariants: hs_write=1 only while hs_access=1; hs_access=1 only while CPU_PAUSE=1 and CPU_PAUSED was seen; CPU_PAUSE deasserted strictly after hs_access.
- CPU_PAUSED dropping mid-transfer is a platform error; the block does not react (behaviour defined only by ABORT).

## Timing
- Reset values: all outputs 0; state IDLE; DUMP_DATA 8'h00; hs_address 11'h000.
- Start to CPU_PAUSE: 1 cycle. CPU_PAUSED seen to hs_access: 1 cycle.
- Dump: 3 cycles per byte minimum (RD_ADDR, RD_DATA, RD_HOLD with DUMP_READY=1). DUMP_DATA stable while DUMP_VALID & ~DUMP_READY.
- Load: 2 cycles per byte minimum (accept, write).
- Last handshake to hs_access low: 1 cycle; to CPU_PAUSE low / DONE: 2 cycles.

## Structure
- Package digdug_hs_pkg: state enum, mode encoding, RAM address width (11), counter width (12).
- Single module; no sub-module needed (datapath is one address register, one counter, one data register).

## Test plan
- HS_BASE=11'h100, HS_LEN=4, RAM preloaded 8'hA0..A3, DUMP_START, CPU_PAUSED after 5 cycles, DUMP_READY=1 -> DUMP_DATA A0,A1,A2,A3; DONE once; CPU_PAUSE falls 1 cycle after hs_access.
- Same dump with DUMP_READY toggling 0/1 -> identical byte sequence, DUMP_DATA held while stalled.
- LOAD_START, HS_LEN=4, host bytes 5A,C3,00,FF with gaps on LOAD_VALID -> RAM 1 $100..$103 = 5A,C3,00,FF; exactly 4 hs_write pulses.
- HS_BASE=11'h7FE, HS_LEN=4 load -> writes at 7FE,7FF,000,001.
- ABORT after 2 of 4 dump bytes -> no DONE, DUMP_VALID low, hs_access low next cycle, CPU_PAUSE low the cycle after; new DUMP_START then works.
- DUMP_START and LOAD_START same cycle -> dump mode; LOAD_START while BUSY ignored; RESET_N low mid-load -> all outputs 0 asynchronously.
